// File: rtl/dft_frame_rx.sv
// Receive stage for block-floating-point DFT output: denormalises each sample with
// saturation, tracks sop/eop framing and frame length, one registered ready/valid stage.
module dft_frame_rx #(
  parameter int DW = 18,
  parameter int OW = 30,
  parameter int PW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [DW-1:0]        in_real,
  input  logic [DW-1:0]        in_imag,
  input  logic [3:0]           in_exp,
  input  logic [PW-1:0]        in_dftpts,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [OW-1:0]        out_real,
  output logic [OW-1:0]        out_imag,
  output logic [PW-1:0]        out_idx,
  output logic                 frame_done,
  output logic                 err_len,
  output logic                 err_sop,
  output logic                 err_orphan,
  output logic [15:0]          frame_cnt
);

  localparam int FW = DW + 15;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t          state, state_nx;
  logic [3:0]      exp_q, exp_nx;
  logic [PW-1:0]   pts_q, pts_nx, idx_q, idx_nx;
  logic            acc, fwd, done, len_bad, sop_err, orphan;

  // Shift at full width so every exponent fits, then clamp to the OW range.
  function automatic logic [OW-1:0] scale(input logic [DW-1:0] m, input logic [3:0] e);
    logic signed [FW-1:0] full, mx, mn;
    full = {{15{m[DW-1]}}, m};
    full = full <<< e;
    mx   = {{(FW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    mn   = ~mx;
    if (full > mx)      return {1'b0, {(OW-1){1'b1}}};
    else if (full < mn) return {1'b1, {(OW-1){1'b0}}};
    else                return full[OW-1:0];
  endfunction

  assign in_ready = !out_valid | out_ready;
  assign acc      = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    exp_nx   = exp_q;
    pts_nx   = pts_q;
    idx_nx   = idx_q;
    fwd      = 1'b0;
    done     = 1'b0;
    len_bad  = 1'b0;
    sop_err  = 1'b0;
    orphan   = 1'b0;
    if (acc) begin
      if (in_sop) begin
        // A sop always starts a fresh frame, even one that interrupts a frame in progress.
        sop_err  = (state == FRAME);
        exp_nx   = in_exp;
        pts_nx   = in_dftpts;
        idx_nx   = '0;
        fwd      = 1'b1;
        state_nx = in_eop ? IDLE : FRAME;
      end else if (state == IDLE) begin
        orphan = 1'b1;
      end else begin
        idx_nx = idx_q + 1'b1;
        fwd    = 1'b1;
        if (in_eop) state_nx = IDLE;
      end
      done    = fwd & in_eop;
      len_bad = done & (({1'b0, idx_nx} + (PW+1)'(1)) != {1'b0, pts_nx});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      exp_q <= '0;
      pts_q <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nx;
      exp_q <= exp_nx;
      pts_q <= pts_nx;
      idx_q <= idx_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_idx    <= '0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      err_sop    <= 1'b0;
      err_orphan <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= done;
      err_len    <= len_bad;
      err_sop    <= sop_err;
      err_orphan <= orphan;
      if (done) frame_cnt <= frame_cnt + 16'd1;
      if (in_ready) begin
        out_valid <= fwd;
        if (fwd) begin
          out_sop  <= in_sop;
          out_eop  <= in_eop;
          out_real <= scale(in_real, exp_nx);
          out_imag <= scale(in_imag, exp_nx);
          out_idx  <= idx_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_dft_frame_rx.sv
// Randomised and directed bench for dft_frame_rx against a frame-level reference model.
module tb_dft_frame_rx;
  localparam int DW = 18, OW = 30, PW = 12;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_sop = 0, in_eop = 0;
  logic [DW-1:0] in_real = 0, in_imag = 0;
  logic [3:0] in_exp = 0;
  logic [PW-1:0] in_dftpts = 0;
  logic out_valid, out_ready = 1, out_sop, out_eop;
  logic [OW-1:0] out_real, out_imag;
  logic [PW-1:0] out_idx;
  logic frame_done, err_len, err_sop, err_orphan;
  logic [15:0] frame_cnt;

  dft_frame_rx #(.DW(DW), .OW(OW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_eop(in_eop), .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp),
    .in_dftpts(in_dftpts), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .out_real(out_real), .out_imag(out_imag), .out_idx(out_idx),
    .frame_done(frame_done), .err_len(err_len), .err_sop(err_sop), .err_orphan(err_orphan),
    .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  typedef struct { bit sop, eop; longint re, im; int idx; } beat_t;
  beat_t q[$];

  int n_cmp = 0, n_bad = 0;
  int pc = 0, rdy_mode = 0;
  // reference model state
  bit m_in_frame = 0; int m_exp = 0, m_pts = 0, m_idx = 0, m_beats = 0, m_cnt = 0;
  bit e_done, e_len, e_sop, e_orph;
  // stall snapshot
  bit st_pend = 0; bit st_sop, st_eop; logic [OW-1:0] st_re, st_im; logic [PW-1:0] st_idx;

  task automatic chk(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic longint scl(input logic [DW-1:0] m, input int e);
    longint f, mx, mn;
    f  = longint'($signed(m)) * (longint'(1) << e);
    mx = (longint'(1) << (OW-1)) - 1;
    mn = -(longint'(1) << (OW-1));
    if (f > mx) return mx;
    if (f < mn) return mn;
    return f;
  endfunction

  function automatic void model(input bit acc, s, e, input logic [DW-1:0] re, im,
                                input int ex, pts);
    beat_t b;
    bit fwd = 0;
    e_done = 0; e_len = 0; e_sop = 0; e_orph = 0;
    if (!acc) return;
    if (s) begin
      e_sop = m_in_frame;
      m_exp = ex; m_pts = pts; m_idx = 0; m_beats = 1; fwd = 1;
      m_in_frame = !e;
    end else if (!m_in_frame) begin
      e_orph = 1;
    end else begin
      m_idx = (m_idx + 1) % (1 << PW); m_beats++; fwd = 1;
      if (e) m_in_frame = 0;
    end
    if (fwd) begin
      b.sop = s; b.eop = e; b.idx = m_idx;
      b.re = scl(re, m_exp); b.im = scl(im, m_exp);
      q.push_back(b);
      if (e) begin
        e_done = 1;
        e_len  = (m_beats != m_pts);
        m_cnt  = (m_cnt + 1) % 65536;
      end
    end
  endfunction

  // One clock: drive at negedge, check pre-edge, check pulses after edge.
  task automatic step(input bit v, s, e, input logic [DW-1:0] re, im, input int ex, pts,
                      output bit acc);
    beat_t b;
    in_valid = v; in_sop = s; in_eop = e; in_real = re; in_imag = im;
    in_exp = 4'(ex); in_dftpts = PW'(pts);
    case (rdy_mode)
      0: out_ready = 1;
      1: out_ready = (pc % 4 == 0) || (pc % 4 == 3);
      default: out_ready = ($urandom % 3) != 0;
    endcase
    pc++;
    #1;
    chk("in_ready", in_ready, !out_valid || out_ready);
    chk("out_valid", out_valid, q.size() != 0);
    if (st_pend) begin
      chk("stall_sop", out_sop, st_sop); chk("stall_eop", out_eop, st_eop);
      chk("stall_real", out_real, st_re); chk("stall_imag", out_imag, st_im);
      chk("stall_idx", out_idx, st_idx);
    end
    st_pend = out_valid && !out_ready;
    st_sop = out_sop; st_eop = out_eop; st_re = out_real; st_im = out_imag; st_idx = out_idx;
    if (out_valid && out_ready && q.size() != 0) begin
      b = q.pop_front();
      chk("out_sop", out_sop, b.sop);
      chk("out_eop", out_eop, b.eop);
      chk("out_real", longint'($signed(out_real)), b.re);
      chk("out_imag", longint'($signed(out_imag)), b.im);
      chk("out_idx", out_idx, b.idx);
    end
    acc = v && in_ready;
    model(acc, s, e, re, im, ex, pts);
    @(posedge clk); #1;
    chk("frame_done", frame_done, e_done);
    chk("err_len", err_len, e_len);
    chk("err_sop", err_sop, e_sop);
    chk("err_orphan", err_orphan, e_orph);
    chk("frame_cnt", frame_cnt, m_cnt);
    @(negedge clk);
  endtask

  task automatic send(input bit s, e, input logic [DW-1:0] re, im, input int ex, pts);
    bit acc = 0;
    for (int t = 0; t < 50 && !acc; t++) step(1, s, e, re, im, ex, pts, acc);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) step(0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic nominal_frame(input int ex, pts, n, sop_at);
    for (int k = 0; k < n; k++)
      send(k == 0 || k == sop_at, k == n-1, DW'(k), DW'(-k), ex, pts);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_cnt", frame_cnt, 0); chk("rst_out_real", out_real, 0);
    chk("rst_pulses", {frame_done, err_len, err_sop, err_orphan}, 0);
    @(negedge clk); @(negedge clk); rst = 0;

    rdy_mode = 0; nominal_frame(3, 12, 12, -1); idle(2);
    rdy_mode = 1; nominal_frame(3, 12, 12, -1); idle(3);
    rdy_mode = 0;
    send(1, 1, 18'h1FFFF, 18'h20000, 15, 1);
    send(1, 1, 18'd100, 18'd0, 12, 1);
    send(1, 1, 18'h1FFFF, 18'h20000, 0, 1);
    idle(2);
    for (int k = 0; k < 1199; k++) send(k == 0, k == 1198, DW'(k), DW'(k*3), 0, 1200);
    idle(2);
    for (int k = 0; k < 3; k++) send(0, 0, DW'(k+7), 0, 0, 0);
    idle(2);
    // sop arrives on beat 5 of a 12-point frame with a new exponent
    for (int k = 0; k < 4; k++) send(k == 0, 0, DW'(k), DW'(-k), 3, 12);
    nominal_frame(5, 12, 12, -1); idle(2);

    // reset mid-frame with a beat still pending on the output
    for (int k = 0; k < 6; k++) send(k == 0, 0, DW'(k+1), DW'(k+2), 2, 12);
    in_valid = 0; out_ready = 0;
    #2 rst = 1; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    q.delete(); st_pend = 0; m_in_frame = 0; m_cnt = 0;
    @(negedge clk); rst = 0;
    nominal_frame(1, 12, 12, -1); idle(2);

    // random frames: gaps, backpressure, orphans, truncated frames, length errors
    rdy_mode = 2;
    for (int f = 0; f < 60; f++) begin
      int n, pts, ex, cut;
      n = $urandom_range(1, 16);
      pts = ($urandom % 4 == 0) ? n + 1 : n;
      ex = $urandom_range(0, 15);
      cut = ($urandom % 8 == 0) ? $urandom_range(1, n) : n + 1;
      if ($urandom % 6 == 0) send(0, 0, DW'($urandom), DW'($urandom), 0, 0);
      for (int k = 0; k < n && k < cut; k++) begin
        if ($urandom % 4 == 0) idle(1);
        send(k == 0, k == n-1, DW'($urandom), DW'($urandom), ex, pts);
      end
    end
    rdy_mode = 0; idle(4);
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
